fir_partial_sum_accumulator: RTL
================================

// Module: fir_partial_sum_accumulator
// PURPOSE
//   Downstream stage of the FIR lane-adder array. Each input beat carries LANES parallel {Cout,S} lane results.
//   Per beat: reduces the lanes to one beat sum, then accumulates beat sums over one tap window
//   (NTAPS beats, or fewer when in_last is set). Presents one filtered sample per window on a valid/ready output.
// PARAMETERS
//   LANES   3   number of adder lanes per beat
//   LANE_W  3   sum bits per lane; lane value = {cout, sum}, LANE_W+1 bits unsigned
//   NTAPS   8   beats per window; must be >= 1
//   ACC_W   12  accumulator/output width
// PORTS
//   clk        in   1              single clock, rising edge
//   rst_n      in   1              asynchronous, active-low reset
//   in_valid   in   1              input beat valid
//   in_ready   out  1              stage can accept a beat
//   in_sum     in   LANES*LANE_W   lane sums; lane k = in_sum[k*LANE_W +: LANE_W]
//   in_cout    in   LANES          lane carry-outs; lane k = in_cout[k]
//   in_last    in   1              beat closes the window early
//   out_valid  out  1              result valid
//   out_ready  in   1              consumer accepts result
//   out_data   out  ACC_W          accumulated window sum
//   out_ovf    out  1              accumulator overflowed during this window
//   tap_cnt    out  $clog2(NTAPS)+1  beats accepted in current window
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; acc=0; tap_cnt=0; out_valid=0; out_data=0; out_ovf=0; in_ready=1.
//     Reset mid-window discards the partial sum.
//   - Lane value: v_k = {in_cout[k], in_sum[k]}.
//   - Beat sum: beat = sum of v_k, in width LANE_W+1+$clog2(LANES). Zero-extend beat to ACC_W+1 before the add.
//   - Accept: a beat is accepted when in_valid && in_ready. in_ready = (state != HOLD).
//   - FSM:
//       IDLE  -> ACCUM  on an accepted beat that is not final: acc <= beat; tap_cnt <= 1.
//       ACCUM -> ACCUM  on an accepted beat that is not final: acc <= acc + beat; tap_cnt++.
//       IDLE/ACCUM -> HOLD on the final beat: out_data <= base + beat (base = 0 in IDLE, acc in ACCUM); out_valid <= 1.
//       HOLD  -> IDLE   when out_ready: out_valid <= 0; acc <= 0; tap_cnt <= 0; out_ovf <= 0.
//   - Final beat: in_last=1, or tap_cnt == NTAPS-1 at acceptance. NTAPS=1 makes every beat final.
//   - Latency: out_valid rises on the clock edge that accepts the final beat, i.e. visible the next cycle.
//   - No input is accepted in HOLD.
//   - HOLD: out_data and out_ovf stay stable while out_valid && !out_ready.
//   - Overflow: bit ACC_W of any add is 1 -> out_ovf sets and stays set (sticky) until the window is consumed.
//   - in_valid with in_ready=0: ignored; the upstream stage must hold its data.
//   - X on in_sum/in_cout while in_valid=0 must not propagate into state.
// CONFIGURATION
//   FIR_ACC_SATURATE_EN defined: on overflow, acc clamps to {ACC_W{1'b1}} and stays clamped for the rest of the window; out_ovf=1.
//   FIR_ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W; out_ovf still reports.
// STRUCTURE
//   Package fir_pkg:
//     - typedef enum {IDLE, ACCUM, HOLD} fir_acc_state_t
//     - localparam function computing beat width from LANES/LANE_W
//   Sub-module fir_lane_reduce: combinational lane-to-beat sum, parameterised LANES/LANE_W.
//   Top holds the FSM, accumulator, tap counter and output register.
// TESTING
//   1 Reset: rst_n=0 -> out_valid=0, in_ready=1, out_data=0, tap_cnt=0, out_ovf=0.
//   2 Full window (defaults): 8 beats, each lane sum=1, cout=0 (beat=3) -> out_data=24 one cycle after beat 8, out_ovf=0.
//   3 Early close: 3 beats of lanes {2,3,5} (beat=10), in_last on beat 3 -> out_data=30, tap_cnt=3.
//   4 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid=1, out_data stable, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle.
//   5 Overflow, ACC_W=8: 8 beats of all-max lanes (beat=45, total 360) -> out_ovf=1;
//     out_data=104 without the macro, 255 with FIR_ACC_SATURATE_EN.
//   6 Reset mid-window: 4 beats of 3, pulse rst_n, then 8 beats of 3 -> out_data=24 (not 36).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR partial-sum accumulator.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } fir_acc_state_t;

    // Width of one beat sum: a lane value plus growth for adding LANES of them.
    function automatic int fir_beat_w(input int lanes, input int lane_w);
        return lane_w + 1 + $clog2(lanes);
    endfunction

endpackage

// File: rtl/fir_lane_reduce.sv
// Combinational reduction of LANES {cout,sum} lane results into one beat sum.
module fir_lane_reduce
    import fir_pkg::*;
#(
    parameter int LANES  = 3,
    parameter int LANE_W = 3
) (
    input  logic [LANES*LANE_W-1:0]                 in_sum,
    input  logic [LANES-1:0]                        in_cout,
    output logic [fir_beat_w(LANES, LANE_W)-1:0]    beat
);

    localparam int BEAT_W = fir_beat_w(LANES, LANE_W);

    logic [BEAT_W-1:0] beat_s;

    // Adder tree over all lanes; each lane is an unsigned LANE_W+1 bit value.
    always_comb begin
        beat_s = {BEAT_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            beat_s = beat_s + BEAT_W'({in_cout[k], in_sum[k*LANE_W +: LANE_W]});
        end
    end

    assign beat = beat_s;

endmodule

// File: rtl/fir_partial_sum_accumulator.sv
// Accumulates lane-reduced beat sums over one tap window and presents the result on valid/ready.
// Optional build macro: FIR_ACC_SATURATE_EN (clamp accumulator on overflow instead of wrapping).
module fir_partial_sum_accumulator
    import fir_pkg::*;
#(
    parameter int LANES  = 3,
    parameter int LANE_W = 3,
    parameter int NTAPS  = 8,
    parameter int ACC_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   in_sum,
    input  logic [LANES-1:0]          in_cout,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      out_ovf,
    output logic [$clog2(NTAPS):0]    tap_cnt
);

    localparam int BEAT_W = fir_beat_w(LANES, LANE_W);
    localparam int TAP_W  = $clog2(NTAPS) + 1;

    fir_acc_state_t state_r, state_nxt_s;

    logic [BEAT_W-1:0]  beat_s;
    logic [BEAT_W-1:0]  beat_gated_s;
    logic [ACC_W-1:0]   acc_r, acc_nxt_s;
    logic [ACC_W-1:0]   base_s;
    logic [ACC_W:0]     sum_s;
    logic [ACC_W-1:0]   add_res_s;
    logic               carry_s;
    logic               accept_s;
    logic               final_s;
    logic [TAP_W-1:0]   tap_cnt_r, tap_nxt_s;
    logic [ACC_W-1:0]   out_data_r, data_nxt_s;
    logic               out_valid_r, valid_nxt_s;
    logic               out_ovf_r, ovf_nxt_s;
    logic               in_ready_r;

    fir_lane_reduce #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_reduce (
        .in_sum  (in_sum),
        .in_cout (in_cout),
        .beat    (beat_s)
    );

    // Idle lanes may carry X; keep them out of the datapath entirely.
    assign beat_gated_s = in_valid ? beat_s : {BEAT_W{1'b0}};

    assign accept_s = in_valid && (state_r != HOLD);
    assign final_s  = in_last || (tap_cnt_r == TAP_W'(NTAPS - 1));
    assign base_s   = (state_r == ACCUM) ? acc_r : {ACC_W{1'b0}};
    assign sum_s    = {1'b0, base_s} + (ACC_W+1)'(beat_gated_s);
    assign carry_s  = sum_s[ACC_W];

`ifdef FIR_ACC_SATURATE_EN
    assign add_res_s = carry_s ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
    assign add_res_s = sum_s[ACC_W-1:0];
`endif

    // Next-state and datapath update for the window FSM.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        tap_nxt_s   = tap_cnt_r;
        data_nxt_s  = out_data_r;
        valid_nxt_s = out_valid_r;
        ovf_nxt_s   = out_ovf_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    tap_nxt_s = tap_cnt_r + TAP_W'(1);
                    ovf_nxt_s = out_ovf_r | carry_s;
                    if (final_s) begin
                        state_nxt_s = HOLD;
                        data_nxt_s  = add_res_s;
                        valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ACCUM;
                        acc_nxt_s   = add_res_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                    acc_nxt_s   = {ACC_W{1'b0}};
                    tap_nxt_s   = {TAP_W{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
                acc_nxt_s   = {ACC_W{1'b0}};
                tap_nxt_s   = {TAP_W{1'b0}};
                ovf_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; in_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            tap_cnt_r   <= {TAP_W{1'b0}};
            out_data_r  <= {ACC_W{1'b0}};
            out_valid_r <= 1'b0;
            out_ovf_r   <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            tap_cnt_r   <= tap_nxt_s;
            out_data_r  <= data_nxt_s;
            out_valid_r <= valid_nxt_s;
            out_ovf_r   <= ovf_nxt_s;
            in_ready_r  <= (state_nxt_s != HOLD);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign tap_cnt   = tap_cnt_r;

endmodule
